// File: rtl/image_receiver.sv
// 8N1 UART receiver that pairs bytes into 12-bit pixels and writes them to a frame buffer.
// Optional trailing XOR checksum byte per frame: define IMAGE_RX_CHECKSUM_EN.
module image_receiver #(
  parameter int CLKS_PER_BIT = 434,
  parameter int NUM_PIXELS   = 76800,
  parameter int TIMEOUT_CLKS = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_in,
  output logic        wr_en,
  output logic [16:0] wr_address,
  output logic [11:0] wr_pixel,
  output logic        image_ready,
  output logic        frame_error
);

  localparam int BIT_W = $clog2(CLKS_PER_BIT);
  localparam int TO_W  = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BIT_W-1:0] BIT_LOAD  = BIT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] HALF_LOAD = BIT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [TO_W-1:0]  TO_ONE    = TO_W'(1);
  localparam logic [16:0]      ADDR_LAST = 17'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
`ifdef IMAGE_RX_CHECKSUM_EN
  typedef enum logic [1:0] {P_WAIT_HI, P_WAIT_LO, P_CHECKSUM} pix_state_t;
`else
  typedef enum logic [1:0] {P_WAIT_HI, P_WAIT_LO} pix_state_t;
`endif

  logic             rx_meta, rx;
  bit_state_t       bit_state, bit_next;
  logic [BIT_W-1:0] bit_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_tc, byte_valid, stop_err;

  pix_state_t       pix_state, pix_next;
  logic [3:0]       hi_nib;
  logic [TO_W-1:0]  to_cnt;
  logic             timer_run, timeout, abort, last_pix;
`ifdef IMAGE_RX_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  // Synchroniser resets to the idle-high line level so reset cannot fake a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx      <= 1'b1;
    end else begin
      rx_meta <= uart_in;
      rx      <= rx_meta;
    end
  end

  assign bit_tc = (bit_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) bit_state <= B_IDLE;
    else     bit_state <= bit_next;
  end

  always_comb begin
    bit_next   = bit_state;
    byte_valid = 1'b0;
    stop_err   = 1'b0;
    case (bit_state)
      B_IDLE:  if (!rx) bit_next = B_START;
      B_START: if (bit_tc) bit_next = rx ? B_IDLE : B_DATA;
      B_DATA:  if (bit_tc && bit_idx == 3'd7) bit_next = B_STOP;
      B_STOP: begin
        if (bit_tc) begin
          bit_next   = B_IDLE;
          byte_valid = rx;
          stop_err   = !rx;
        end
      end
      default: bit_next = B_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (bit_state)
        B_IDLE:  bit_cnt <= HALF_LOAD;
        B_START: begin
          bit_cnt <= bit_tc ? BIT_LOAD : bit_cnt - BIT_ONE;
          bit_idx <= '0;
        end
        B_DATA: begin
          if (bit_tc) begin
            shift   <= {rx, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            bit_cnt <= BIT_LOAD;
          end else begin
            bit_cnt <= bit_cnt - BIT_ONE;
          end
        end
        B_STOP:  if (!bit_tc) bit_cnt <= bit_cnt - BIT_ONE;
        default: bit_cnt <= '0;
      endcase
    end
  end

  // Timer only runs inside a frame; a byte landing on the timeout cycle wins.
  assign timer_run = (pix_state != P_WAIT_HI) || (wr_address != '0);
  assign timeout   = timer_run && !byte_valid && (to_cnt == TO_LAST);
  assign abort     = stop_err || timeout;
  assign last_pix  = (wr_address == ADDR_LAST);

  always_ff @(posedge clk) begin
    if (rst) pix_state <= P_WAIT_HI;
    else     pix_state <= pix_next;
  end

  always_comb begin
    pix_next = pix_state;
    if (abort) begin
      pix_next = P_WAIT_HI;
    end else if (byte_valid) begin
      case (pix_state)
        P_WAIT_HI: pix_next = P_WAIT_LO;
`ifdef IMAGE_RX_CHECKSUM_EN
        P_WAIT_LO:  pix_next = last_pix ? P_CHECKSUM : P_WAIT_HI;
        P_CHECKSUM: pix_next = P_WAIT_HI;
`else
        P_WAIT_LO:  pix_next = P_WAIT_HI;
`endif
        default:    pix_next = P_WAIT_HI;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en       <= 1'b0;
      wr_address  <= '0;
      wr_pixel    <= '0;
      image_ready <= 1'b0;
      frame_error <= 1'b0;
      hi_nib      <= '0;
      to_cnt      <= '0;
`ifdef IMAGE_RX_CHECKSUM_EN
      csum        <= '0;
`endif
    end else begin
      wr_en       <= 1'b0;
      frame_error <= abort;

      if (byte_valid || abort) to_cnt <= '0;
      else if (timer_run)      to_cnt <= to_cnt + TO_ONE;

      if (wr_en) begin
        wr_address <= last_pix ? '0 : wr_address + 17'd1;
`ifndef IMAGE_RX_CHECKSUM_EN
        if (last_pix) image_ready <= 1'b1;
`endif
      end
      if (abort) wr_address <= '0;

      if (byte_valid) begin
        case (pix_state)
          P_WAIT_HI: begin
            hi_nib      <= shift[3:0];
            image_ready <= 1'b0;
`ifdef IMAGE_RX_CHECKSUM_EN
            csum <= (wr_address == '0) ? shift : csum ^ shift;
`endif
          end
          P_WAIT_LO: begin
            wr_en    <= 1'b1;
            wr_pixel <= {hi_nib, shift};
`ifdef IMAGE_RX_CHECKSUM_EN
            csum <= csum ^ shift;
`endif
          end
`ifdef IMAGE_RX_CHECKSUM_EN
          P_CHECKSUM: begin
            if (shift == csum) image_ready <= 1'b1;
            else               frame_error <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_image_receiver.sv
// Scoreboard bench for image_receiver: stimulus queues expected writes, a monitor pops them on wr_en.
module tb_image_receiver;

  localparam int CPB  = 8;
  localparam int NPIX = 9;
  localparam int TO   = 200;
  // Start-bit drive edge to byte_valid edge: 2 sync + 1 idle + half bit + 8 data bits + stop bit.
  localparam int BYTE_LAT = 3 + CPB / 2 + 9 * CPB;
  localparam logic [7:0] CSUM_GOOD = 8'h0F;

  logic        clk = 1'b0;
  logic        rst;
  logic        uart_in;
  logic        wr_en;
  logic [16:0] wr_address;
  logic [11:0] wr_pixel;
  logic        image_ready;
  logic        frame_error;

  image_receiver #(
    .CLKS_PER_BIT(CPB),
    .NUM_PIXELS(NPIX),
    .TIMEOUT_CLKS(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .uart_in(uart_in),
    .wr_en(wr_en),
    .wr_address(wr_address),
    .wr_pixel(wr_pixel),
    .image_ready(image_ready),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int pix;
    int cyc;
  } wr_t;

  wr_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   err_pulses = 0;
  int   err_last_cyc = 0;
  int   last_start = 0;
  logic [11:0] frame [NPIX];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (frame_error) begin
      err_pulses++;
      err_last_cyc = cyc;
    end
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: addr %0d pixel %h, nothing expected", wr_address, wr_pixel);
      end else begin
        e = exp_q.pop_front();
        chk("wr_address", int'(wr_address), e.addr);
        chk("wr_pixel", int'(wr_pixel), e.pix);
        chk("wr_latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int push_addr,
                           input int push_pix);
    wr_t w;
    @(posedge clk); #1;
    uart_in    = 1'b0;
    last_start = cyc;
    if (push_addr >= 0) begin
      w.addr = push_addr;
      w.pix  = push_pix;
      w.cyc  = cyc + BYTE_LAT;
      exp_q.push_back(w);
    end
    repeat (CPB) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_in = stop_bit;
    repeat (CPB) @(posedge clk);
    #1;
    uart_in = 1'b1;
  endtask

  task automatic send_pixel(input int idx);
    send_byte({4'h0, frame[idx][11:8]}, 1'b1, -1, 0);
    send_byte(frame[idx][7:0], 1'b1, idx, int'(frame[idx]));
  endtask

  task automatic send_frame();
    for (int i = 0; i < NPIX; i++) send_pixel(i);
`ifdef IMAGE_RX_CHECKSUM_EN
    send_byte(CSUM_GOOD, 1'b1, -1, 0);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_frame_done(input string tag, input int exp_err);
    chk({tag, "_image_ready"}, int'(image_ready), 1);
    chk({tag, "_wr_address"}, int'(wr_address), 0);
    chk({tag, "_err_pulses"}, err_pulses, exp_err);
    chk({tag, "_writes_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NPIX; i++) frame[i] = (i >= 3 && i <= 5) ? 12'hF00 : 12'h00F;
    rst     = 1'b1;
    uart_in = 1'b1;
    idle(3);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_address", int'(wr_address), 0);
    chk("rst_wr_pixel", int'(wr_pixel), 0);
    chk("rst_image_ready", int'(image_ready), 0);
    chk("rst_frame_error", int'(frame_error), 0);
    rst = 1'b0;
    idle(5);

    // Clean frame
    send_frame();
    check_frame_done("frame1", 0);

    // Stop bit of byte 5 (low byte of pixel 2) held low
    send_pixel(0);
    send_pixel(1);
    chk("badstop_ready_cleared", int'(image_ready), 0);
    send_byte({4'h0, frame[2][11:8]}, 1'b1, -1, 0);
    send_byte(frame[2][7:0], 1'b0, -1, 0);
    idle(40);
    chk("badstop_err_pulses", err_pulses, 1);
    send_frame();
    check_frame_done("badstop_resend", 1);

    // Seven bytes then silence
    for (int i = 0; i < 3; i++) send_pixel(i);
    send_byte({4'h0, frame[3][11:8]}, 1'b1, -1, 0);
    idle(TO + 20);
    chk("timeout_err_pulses", err_pulses, 2);
    chk("timeout_err_cycle", err_last_cyc, last_start + BYTE_LAT + TO);
    chk("timeout_ready_low", int'(image_ready), 0);
    send_frame();
    check_frame_done("timeout_resend", 2);

    // Two-clock low glitch
    @(posedge clk); #1;
    uart_in = 1'b0;
    idle(2);
    uart_in = 1'b1;
    idle(40);
    chk("glitch_err_pulses", err_pulses, 2);
    chk("glitch_ready_kept", int'(image_ready), 1);
    send_frame();
    check_frame_done("glitch_frame", 2);

    // Reset during data bits of pixel 4's low byte
    for (int i = 0; i < 4; i++) send_pixel(i);
    send_byte({4'h0, frame[4][11:8]}, 1'b1, -1, 0);
    @(posedge clk); #1;
    uart_in = 1'b0;
    idle(3 * CPB);
    rst = 1'b1;
    idle(1);
    chk("midrst_wr_en", int'(wr_en), 0);
    chk("midrst_wr_address", int'(wr_address), 0);
    chk("midrst_wr_pixel", int'(wr_pixel), 0);
    chk("midrst_image_ready", int'(image_ready), 0);
    chk("midrst_frame_error", int'(frame_error), 0);
    rst     = 1'b0;
    uart_in = 1'b1;
    idle(40);
    send_frame();
    check_frame_done("midrst_frame", 2);

`ifdef IMAGE_RX_CHECKSUM_EN
    for (int i = 0; i < NPIX; i++) send_pixel(i);
    send_byte(CSUM_GOOD ^ 8'h01, 1'b1, -1, 0);
    idle(4);
    chk("csum_bad_err_pulses", err_pulses, 3);
    chk("csum_bad_ready", int'(image_ready), 0);
    send_frame();
    check_frame_done("csum_good", 3);
`endif

    idle(20);
    chk("final_writes_pending", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/image_receiver.md
Name: image_receiver

Overview:
- UART receiver and pixel assembler. It is the FPGA-side consumer of the 12-bit pixel stream that image_sender produces over GPIO UART.
- It deserialises 8N1 bytes and pairs them into 12-bit pixels.
- Each pixel is written to a frame buffer through a single-cycle write port.
- It flags completion after NUM_PIXELS pixels, and flags errors on framing faults and on inter-byte timeouts.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200).
- NUM_PIXELS, 76800, pixels per frame (320x240).
- TIMEOUT_CLKS, 50000, idle clk cycles allowed between bytes inside a frame before abort.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- rst  input  1  synchronous, active-high reset.
- uart_in  input  1  asynchronous serial line, idle high.
- wr_en  output  1  one-cycle strobe; wr_address/wr_pixel valid.
- wr_address  output  17  frame-buffer write address, 0..NUM_PIXELS-1.
- wr_pixel  output  12  assembled pixel {R[3:0],G[3:0],B[3:0]}.
- image_ready  output  1  level; high after a complete frame until the next frame's first byte or rst.
- frame_error  output  1  one-cycle pulse on a stop-bit fault or a timeout abort.

Behaviour:
- Reset (synchronous, rst=1 on a clk edge): wr_en=0, wr_address=0, wr_pixel=0, image_ready=0, frame_error=0. Both FSMs return to their idle states and all counters clear. A reset mid-byte or mid-frame discards all partial data.
- Input sync: uart_in passes through a 2-flop synchroniser. All logic uses the synchronised bit.
- Bit FSM states:
  - IDLE: wait for the line to go low.
  - START: count CLKS_PER_BIT/2 (integer division). If the line is still low, go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT. A 1 gives byte_valid for one cycle. A 0 gives frame_error for one cycle, no byte, and an assembler abort.
  - After STOP the FSM returns to IDLE.
- Byte format:
  - High byte = {4'b0000, pixel[11:8]}; its upper nibble is ignored on receive.
  - Low byte = pixel[7:0].
- Pixel FSM states:
  - WAIT_HI: on byte_valid, latch the high nibble and go to WAIT_LO. If image_ready=1, clear it on this byte.
  - WAIT_LO: on byte_valid, wr_pixel={hi,byte} and wr_en=1 on the next cycle with the current wr_address. On the cycle after wr_en, wr_address increments. If this was pixel NUM_PIXELS-1, wr_address wraps to 0, image_ready=1, and the FSM returns to WAIT_HI.
- Latency: wr_en is asserted exactly 1 clk after the stop-bit byte_valid of the low byte.
- Timeout:
  - A counter runs whenever the pixel FSM is not in WAIT_HI, or when wr_address!=0.
  - It resets on every byte_valid.
  - Reaching TIMEOUT_CLKS gives frame_error for one cycle, wr_address=0, state WAIT_HI, with image_ready unchanged (stays 0).
  - The counter does not run between frames.
- Simultaneous events:
  - rst has priority over everything.
  - A timeout and a byte_valid on the same cycle resolve in favour of the byte (the byte is accepted and the counter clears).
- wr_pixel holds its last value between strobes. wr_address is only valid while wr_en=1.
- Counter widths: bit counter sized by $clog2(CLKS_PER_BIT), timeout counter by $clog2(TIMEOUT_CLKS+1).

Optional Feature:
- Macro: IMAGE_RX_CHECKSUM_EN.
- When defined:
  - After the last low byte, a CHECKSUM state expects one extra byte equal to the XOR of all 2*NUM_PIXELS data bytes of the frame.
  - The last pixel's wr_en is issued as normal.
  - image_ready sets only on a checksum match.
  - A mismatch gives frame_error for one cycle with image_ready=0.
  - A timeout while waiting for the checksum byte also gives frame_error.
- When undefined: there is no CHECKSUM state, and image_ready sets immediately after the last pixel.

Test Plan:
- CLKS_PER_BIT=8, NUM_PIXELS=9: send image_sender's test frame (pixels 0-2 and 6-8 = 12'h00F, pixels 3-5 = 12'hF00) as 18 bytes. Required response: nine wr_en strobes at addresses 0..8 with the matching pixels, then image_ready=1 and wr_address=0.
- Stop bit forced to 0 on byte 5: frame_error pulses once. Resending the full frame then gives 9 correct writes starting at address 0.
- Send 7 bytes, then idle for TIMEOUT_CLKS (set to 200): frame_error pulses at cycle 200 after the last stop bit. The next byte is treated as a high byte at address 0.
- Low pulse on uart_in lasting 2 clks (shorter than half a bit): no byte_valid, no wr_en, no error.
- Assert rst during the data bits of pixel 4's low byte: all outputs are 0 on the next cycle. A new full frame then writes addresses 0..8 correctly.
- With IMAGE_RX_CHECKSUM_EN defined: a correct XOR byte gives image_ready=1. Sending that checksum byte ^8'h01 gives a frame_error pulse and image_ready=0.
